// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: deframing states and oversampling constants,
// also intended for the transmitter.
package uart_receiver_pkg;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] MID_TICK   = 4'd7;
  localparam logic [3:0] LAST_TICK  = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_receiver_if.sv
// Receive-word holding register port: valid/ready handshake plus per-word flags.
interface uart_receiver_if #(parameter int DATA_BITS = 8);

  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_valid;
  logic                 rd_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun_err;

  modport master (
    output rd_data, rd_valid, parity_err, frame_err, overrun_err,
    input  rd_ready
  );

  modport slave (
    input  rd_data, rd_valid, parity_err, frame_err, overrun_err,
    output rd_ready
  );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous inputs; resets to 1 so an idle-high
// line never looks like a falling edge coming out of reset.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] ff_q, ff_d;

  always_comb ff_d = {ff_q[0], d};

  always_ff @(posedge clk) begin
    if (rst) ff_q <= 2'b11;
    else     ff_q <= ff_d;
  end

  assign q = ff_q[1];

endmodule

// File: rtl/uart_receiver.sv
// UART receive engine: 16x-oversampled deframer feeding a one-entry
// valid/ready holding register with parity, frame and sticky overrun flags.
//
// state  | meaning
// IDLE   | line idle, waiting for a low sample on a tick
// START  | counting to mid start bit to confirm it
// DATA   | sampling data bits LSB first at each bit centre
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit, then delivering the word
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_tick,
  input  logic rx_in,
  output logic busy,
  uart_receiver_if.master rd_if
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic       ODD      = (PARITY_ODD != 0);

  logic rx_s;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

  uart_state_e          state_q, state_d;
  logic [3:0]           tick_cnt_q, tick_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rd_data_q, rd_data_d;
  logic                 par_bad_q, par_bad_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 deliver;
  logic                 stop_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tick_cnt_q   <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      rd_data_q    <= '0;
      par_bad_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      rd_data_q    <= rd_data_d;
      par_bad_q    <= par_bad_d;
      rd_valid_q   <= rd_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    rd_data_d    = rd_data_q;
    par_bad_d    = par_bad_q;
    rd_valid_d   = rd_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
    deliver      = 1'b0;
    stop_bad     = 1'b0;

    if (rd_valid_q && rd_if.rd_ready) rd_valid_d = 1'b0;

    if (rx_tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_d    = ST_START;
            tick_cnt_d = '0;
          end
        end
        ST_START: begin
          if (tick_cnt_q == MID_TICK) begin
            tick_cnt_d = '0;
            if (!rx_s) begin
              state_d   = ST_DATA;
              bit_idx_d = '0;
              par_bad_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
        ST_DATA: begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            for (int i = 0; i < DATA_BITS; i++) begin
              if (i == int'(bit_idx_q)) shift_d[i] = rx_s;
            end
            if (bit_idx_q == LAST_BIT) state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            else                       bit_idx_d = bit_idx_q + 3'd1;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
        ST_PARITY: begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            par_bad_d  = ((^shift_q) ^ rx_s) != ODD;
            state_d    = ST_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
        ST_STOP: begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            deliver    = 1'b1;
            stop_bad   = !rx_s;
            state_d    = ST_IDLE;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A consumer read in the deliver cycle frees the slot for the new word.
    if (deliver) begin
      if (!rd_valid_q || rd_if.rd_ready) begin
        rd_data_d    = shift_q;
        parity_err_d = par_bad_q;
        frame_err_d  = stop_bad;
        rd_valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign rd_if.rd_data     = rd_data_q;
  assign rd_if.rd_valid    = rd_valid_q;
  assign rd_if.parity_err  = parity_err_q;
  assign rd_if.frame_err   = frame_err_q;
  assign rd_if.overrun_err = overrun_q;
  assign busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed and randomized bench for uart_receiver: one instance with default
// framing, one with even parity, checked against a frame-level model.
module tb_uart_receiver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_tick = 1'b0;
  logic rx0 = 1'b1;
  logic rx1 = 1'b1;
  logic busy0, busy1;

  int tick_div = 66;
  int tdiv_cnt = 0;
  int checks = 0;
  int failures = 0;

  int         acc0_n = 0, acc1_n = 0;
  logic [7:0] acc0_data, acc1_data;
  logic       acc0_pe, acc0_fe, acc1_pe, acc1_fe;

  uart_receiver_if #(.DATA_BITS(8)) ifc0 ();
  uart_receiver_if #(.DATA_BITS(8)) ifc1 ();

  uart_receiver #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .rst(rst), .rx_tick(rx_tick), .rx_in(rx0), .busy(busy0), .rd_if(ifc0)
  );

  uart_receiver #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
    .clk(clk), .rst(rst), .rx_tick(rx_tick), .rx_in(rx1), .busy(busy1), .rd_if(ifc1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tdiv_cnt >= tick_div - 1) begin
      tdiv_cnt = 0;
      rx_tick  = 1'b1;
    end else begin
      tdiv_cnt++;
      rx_tick = 1'b0;
    end
  end

  // Record every accepted word (valid && ready) on each port.
  always @(negedge clk) begin
    if (ifc0.rd_valid && ifc0.rd_ready) begin
      acc0_n++;
      acc0_data = ifc0.rd_data;
      acc0_pe   = ifc0.parity_err;
      acc0_fe   = ifc0.frame_err;
    end
    if (ifc1.rd_valid && ifc1.rd_ready) begin
      acc1_n++;
      acc1_data = ifc1.rd_data;
      acc1_pe   = ifc1.parity_err;
      acc1_fe   = ifc1.frame_err;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_perr(input logic [7:0] d, input logic pb, input bit odd);
    return ((($countones(d) + int'(pb)) % 2) != 0) != odd;
  endfunction

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (rx_tick) k++;
    end
    #1;
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx1 = v;
    else     rx0 = v;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] data, input bit par_en,
                            input logic par_bit, input logic stop_bit);
    drive(sel, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      drive(sel, data[i]);
      wait_ticks(16);
    end
    if (par_en) begin
      drive(sel, par_bit);
      wait_ticks(16);
    end
    drive(sel, stop_bit);
    wait_ticks(16);
    drive(sel, 1'b1);
  endtask

  initial begin
    int         n0;
    logic [7:0] d;
    logic       pb, sb;

    ifc0.rd_ready = 1'b1;
    ifc1.rd_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_rd_data", 32'(ifc0.rd_data), 32'h0);
    check("rst_rd_valid", 32'(ifc0.rd_valid), 32'h0);
    check("rst_parity_err", 32'(ifc0.parity_err), 32'h0);
    check("rst_frame_err", 32'(ifc0.frame_err), 32'h0);
    check("rst_overrun_err", 32'(ifc0.overrun_err), 32'h0);
    check("rst_busy", 32'(busy0), 32'h0);
    rst = 1'b0;
    wait_ticks(4);

    // 0x55 at the real baud-rate tick spacing
    n0 = acc0_n;
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
    wait_ticks(2);
    check("w55_count", 32'(acc0_n), 32'(n0 + 1));
    check("w55_data", 32'(acc0_data), 32'h55);
    check("w55_perr", 32'(acc0_pe), 32'h0);
    check("w55_ferr", 32'(acc0_fe), 32'h0);
    check("w55_ovr", 32'(ifc0.overrun_err), 32'h0);
    check("w55_valid_drop", 32'(ifc0.rd_valid), 32'h0);

    tick_div = 4;
    wait_ticks(4);

    // parity instance: good and bad parity on 0xA3
    for (int p = 0; p < 2; p++) begin
      pb = (p != 0);
      n0 = acc1_n;
      send_frame(1'b1, 8'hA3, 1'b1, pb, 1'b1);
      wait_ticks(2);
      check("a3_count", 32'(acc1_n), 32'(n0 + 1));
      check("a3_data", 32'(acc1_data), 32'hA3);
      check("a3_perr", 32'(acc1_pe), 32'(exp_perr(8'hA3, pb, 1'b0)));
      check("a3_ferr", 32'(acc1_fe), 32'h0);
    end

    // false start: low for 4 ticks, start is rejected at the 8th tick after detection
    n0 = acc0_n;
    drive(1'b0, 1'b0);
    wait_ticks(2);
    check("fs_busy_rise", 32'(busy0), 32'h1);
    wait_ticks(2);
    drive(1'b0, 1'b1);
    wait_ticks(4);
    check("fs_busy_still", 32'(busy0), 32'h1);
    wait_ticks(1);
    check("fs_busy_fall", 32'(busy0), 32'h0);
    wait_ticks(8);
    check("fs_no_word", 32'(acc0_n), 32'(n0));

    // frame error: stop bit low
    n0 = acc0_n;
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    wait_ticks(16);
    check("fe_count", 32'(acc0_n), 32'(n0 + 1));
    check("fe_data", 32'(acc0_data), 32'h3C);
    check("fe_ferr", 32'(acc0_fe), 32'h1);

    // overrun: consumer stalled across two frames
    ifc0.rd_ready = 1'b0;
    n0 = acc0_n;
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    wait_ticks(2);
    check("ov_valid", 32'(ifc0.rd_valid), 32'h1);
    check("ov_data_held", 32'(ifc0.rd_data), 32'h11);
    check("ov_ferr_held", 32'(ifc0.frame_err), 32'h0);
    check("ov_sticky", 32'(ifc0.overrun_err), 32'h1);
    ifc0.rd_ready = 1'b1;
    @(posedge clk);
    #1;
    ifc0.rd_ready = 1'b0;
    check("ov_consumed", 32'(acc0_data), 32'h11);
    check("ov_count", 32'(acc0_n), 32'(n0 + 1));
    check("ov_valid_drop", 32'(ifc0.rd_valid), 32'h0);
    ifc0.rd_ready = 1'b1;
    send_frame(1'b0, 8'h33, 1'b0, 1'b0, 1'b1);
    wait_ticks(2);
    check("ov_third", 32'(acc0_data), 32'h33);
    check("ov_third_count", 32'(acc0_n), 32'(n0 + 2));
    check("ov_still_sticky", 32'(ifc0.overrun_err), 32'h1);

    // reset during data bit 3 of 0x7E
    drive(1'b0, 1'b0);
    wait_ticks(16);
    d = 8'h7E;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, d[i]);
      wait_ticks(16);
    end
    drive(1'b0, d[3]);
    wait_ticks(4);
    check("mr_busy_before", 32'(busy0), 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mr_rd_data", 32'(ifc0.rd_data), 32'h0);
    check("mr_rd_valid", 32'(ifc0.rd_valid), 32'h0);
    check("mr_perr", 32'(ifc0.parity_err), 32'h0);
    check("mr_ferr", 32'(ifc0.frame_err), 32'h0);
    check("mr_ovr", 32'(ifc0.overrun_err), 32'h0);
    check("mr_busy", 32'(busy0), 32'h0);
    rst = 1'b0;
    drive(1'b0, 1'b1);
    wait_ticks(20);
    n0 = acc0_n;
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
    wait_ticks(2);
    check("mr_after_count", 32'(acc0_n), 32'(n0 + 1));
    check("mr_after_data", 32'(acc0_data), 32'h81);
    check("mr_after_ferr", 32'(acc0_fe), 32'h0);

    // random frames on the parity instance
    for (int r = 0; r < 6; r++) begin
      d  = 8'($urandom_range(0, 255));
      pb = 1'($urandom_range(0, 1));
      sb = ($urandom_range(0, 3) != 0);
      n0 = acc1_n;
      send_frame(1'b1, d, 1'b1, pb, sb);
      wait_ticks(sb ? 2 : 16);
      check("rnd_count", 32'(acc1_n), 32'(n0 + 1));
      check("rnd_data", 32'(acc1_data), 32'(d));
      check("rnd_perr", 32'(acc1_pe), 32'(exp_perr(d, pb, 1'b0)));
      check("rnd_ferr", 32'(acc1_fe), 32'(!sb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive engine for the APB UART peripheral.
- Consumes the 16x-oversampled rx_tick strobe from the baud clock generator and deframes start/data/optional parity/stop bits from rx_in.
- Presents each received word through a one-entry valid/ready holding register read by the APB UART register block.

Parameters:
- DATA_BITS, 8, data bits per frame (5..8), sent LSB first.
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- rx_tick  input  1  one-clk pulse at 16x baud rate, from the baud clock generator.
- rx_in  input  1  asynchronous serial line, idle high.
- rd_data  output  DATA_BITS  received word.
- rd_valid  output  1  rd_data and the error flags are valid.
- rd_ready  input  1  consumer accepts the word when rd_valid && rd_ready.
- parity_err  output  1  parity mismatch for the held word.
- frame_err  output  1  stop bit sampled low for the held word.
- overrun_err  output  1  sticky: a frame was dropped because the holding register was full.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high. All state changes happen on posedge clk.
- Reset values:
  - rd_data = 0; rd_valid, parity_err, frame_err, overrun_err, busy = 0.
  - FSM = IDLE; tick_cnt = 0; bit_idx = 0.
  - Both synchronizer flops = 1.
- rx_in passes through a 2-flop synchronizer (rx_s). All sampling uses rx_s, and only in cycles where rx_tick = 1.
- tick_cnt is 4 bits. It increments only on rx_tick. In each state it is cleared on entry and on each sample.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on rx_tick with rx_s = 0, go to START, tick_cnt = 0.
  - START: on rx_tick, if tick_cnt = 7 (mid start bit):
    - rx_s = 0: go to DATA, tick_cnt = 0, bit_idx = 0.
    - rx_s = 1: false start, go to IDLE with no output.
    - Otherwise tick_cnt++.
  - DATA: on rx_tick, if tick_cnt = 15:
    - Sample rx_s into shift register bit bit_idx (LSB first); tick_cnt = 0.
    - If bit_idx = DATA_BITS-1, go to PARITY (PARITY_EN=1) or STOP; else bit_idx++.
  - PARITY: at tick_cnt = 15, sample the parity bit.
    - Error when XOR(data, parity bit) != PARITY_ODD.
    - Go to STOP.
  - STOP: at tick_cnt = 15, sample the stop bit; frame error if it is 0.
    - Perform the deliver action below.
    - Go to IDLE in the same cycle, so a start edge is detectable from the next tick.
- Deliver (the clk cycle with the mid-stop sample):
  - Holding register empty, or rd_ready = 1 in this same cycle: load rd_data, parity_err, frame_err; rd_valid = 1 next cycle.
  - Holding register full and rd_ready = 0: new word discarded; overrun_err set; held word and its flags unchanged.
- Words with parity or frame errors are still delivered, with the flags set.
- Handshake:
  - rd_valid stays high until a cycle with rd_ready = 1; it then drops next cycle unless a deliver occurs in that same cycle.
  - rd_data and its flags are stable while rd_valid = 1 and rd_ready = 0.
- overrun_err clears only on rst.
- Latency: rd_valid rises 1 clk after the rx_tick that samples mid stop bit, i.e. about 8 + 16*(DATA_BITS + PARITY_EN) + 16 ticks after the start edge is seen.
- A break (rx_s held low): delivers a word of 0 with frame_err = 1, then re-enters START on the next tick while the line stays low.
- rst mid-frame: the frame is abandoned, all outputs return to reset values, and the FSM is in IDLE next cycle.
- rx_in transitions between ticks have no effect except through the synchronizer.

Decomposition:
- Shared uart package/include:
  - FSM state encodings (IDLE, START, DATA, PARITY, STOP).
  - OVERSAMPLE = 16, MID_TICK = 7, LAST_TICK = 15.
  - The same constants are reused by the future uart_transmitter.
- One sub-module, uart_sync2: 2-flop synchronizer with reset value 1, reusable for other async inputs such as GPIO.

Test Plan:
- Default parameters, ticks every 66 clks (10 MHz / 9600 baud); send 0x55 with 1 stop bit, rd_ready = 1 → one rd_valid pulse, rd_data = 0x55, all error flags 0.
- PARITY_EN=1, PARITY_ODD=0; send 0xA3 with parity bit 0 → rd_data = 0xA3, parity_err = 0. Resend 0xA3 with parity bit 1 → parity_err = 1, word still delivered.
- Pull rx_in low for 4 ticks, then high → busy rises, then falls at tick 8; no rd_valid.
- Send 0x3C with the stop bit forced to 0 → rd_data = 0x3C, frame_err = 1.
- rd_ready = 0; send 0x11 then 0x22 back-to-back → rd_data stays 0x11 and overrun_err = 1. Assert rd_ready → 0x11 is consumed and rd_valid drops. A third frame, 0x33, delivers normally.
- Assert rst during data bit 3 of 0x7E → every output returns to its reset value next clk. A following frame 0x81 is received correctly.
